// File: rtl/pipeline_hazard_controller_pkg.sv
// ============================================================================
// Module   : pipeline_hazard_controller_pkg
// Brief    : Shared constants, state encoding and hazard helper for the
//            pipeline hazard controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_controller_pkg;

    localparam int c_DEF_CNT_W       = 16;
    localparam int c_DEF_MEM_TIMEOUT = 255;

    typedef enum logic [1:0] {
        c_ST_RUN      = 2'd0,
        c_ST_REDIRECT = 2'd1,
        c_ST_MEM_WAIT = 2'd2
    } hz_state_e;

    // A load into x0 never creates a dependency, whatever decode reads.
    function automatic logic f_load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Stall/flush control for load-use, redirect and data-memory waits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_W       = c_DEF_CNT_W,
    parameter int MEM_TIMEOUT = c_DEF_MEM_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_mem_read_i,
    input  logic             de_isbranchtaken_i,
    input  logic             de_jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_stall_o,
    output logic             fd_stall_o,
    output logic             fd_flush_o,
    output logic             de_flush_o,
    output logic             em_stall_o,
    output logic [1:0]       state_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int c_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // The wait counter holds completed MEM_WAIT cycles, so the last allowed
    // cycle is the one where it already reads MEM_TIMEOUT-1.
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
        c_WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = {{(c_WAIT_W-1){1'b0}}, 1'b1};

    hz_state_e           r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout;

    logic w_load_use;
    logic w_redirect;
    logic w_mem_busy;
    logic w_wait_expired;
    logic w_pc_stall;
    logic w_fd_stall;
    logic w_fd_flush;
    logic w_de_flush;
    logic w_em_stall;

    assign w_load_use     = f_load_use(de_mem_read_i, de_rd_i, id_rs1_i, id_rs2_i,
                                       id_uses_rs1_i, id_uses_rs2_i);
    assign w_redirect     = de_isbranchtaken_i | de_jump_i;
    assign w_mem_busy     = dmem_req_i & ~dmem_ready_i;
    assign w_wait_expired = (r_wait_cnt >= c_WAIT_LAST);

    // Controls are gated by reset so a held reset reads as a quiet pipeline.
    always_comb begin
        w_pc_stall = 1'b0;
        w_fd_stall = 1'b0;
        w_fd_flush = 1'b0;
        w_de_flush = 1'b0;
        w_em_stall = 1'b0;
        if (reset_i) begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_mem_busy) begin
                        w_pc_stall = 1'b1;
                        w_fd_stall = 1'b1;
                        w_em_stall = 1'b1;
                    end else if (w_redirect) begin
                        w_fd_flush = 1'b1;
                        w_de_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_stall = 1'b1;
                        w_fd_stall = 1'b1;
                        w_de_flush = 1'b1;
                    end
                end
                c_ST_REDIRECT: begin
                    w_fd_flush = 1'b1;
                end
                c_ST_MEM_WAIT: begin
                    if (!dmem_ready_i) begin
                        w_pc_stall = 1'b1;
                        w_fd_stall = 1'b1;
                        w_em_stall = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_mem_busy) begin
                        r_state    <= c_ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end else if (w_redirect) begin
                        r_state <= c_ST_REDIRECT;
                    end
                end
                c_ST_REDIRECT: begin
                    r_state <= w_mem_busy ? c_ST_MEM_WAIT : c_ST_RUN;
                end
                c_ST_MEM_WAIT: begin
                    if (dmem_ready_i) begin
                        r_state    <= c_ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_state    <= c_ST_RUN;
                        r_wait_cnt <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                    end
                end
                default: begin
                    r_state    <= c_ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (clk_i),
        .rst_n   (reset_i),
        .i_inc   (w_pc_stall),
        .o_count (stall_count_o)
    );

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_flush_cnt (
        .clk     (clk_i),
        .rst_n   (reset_i),
        .i_inc   (w_fd_flush | w_de_flush),
        .o_count (flush_count_o)
    );

    assign pc_stall_o    = w_pc_stall;
    assign fd_stall_o    = w_fd_stall;
    assign fd_flush_o    = w_fd_flush;
    assign de_flush_o    = w_de_flush;
    assign em_stall_o    = w_em_stall;
    assign state_o       = r_state;
    assign mem_timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Brief    : Scoreboard bench: directed scenarios plus random traffic against
//            a cycle-level behavioural model of the hazard rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

    localparam int c_CNT_W   = 16;
    localparam int c_TIMEOUT = 4;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       br;
        logic       jp;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        bit chk;
        int cyc;
        int pc;
        int fds;
        int fdf;
        int def;
        int em;
        int st;
        int to;
        int sc;
        int fc;
    } exp_t;

    logic clk;
    logic reset_i;
    logic [4:0] id_rs1_i, id_rs2_i, de_rd_i;
    logic id_uses_rs1_i, id_uses_rs2_i, de_mem_read_i;
    logic de_isbranchtaken_i, de_jump_i, dmem_req_i, dmem_ready_i;
    logic pc_stall_o, fd_stall_o, fd_flush_o, de_flush_o, em_stall_o;
    logic [1:0] state_o;
    logic mem_timeout_o;
    logic [c_CNT_W-1:0] stall_count_o, flush_count_o;

    pipeline_hazard_controller #(
        .CNT_W       (c_CNT_W),
        .MEM_TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .id_rs1_i           (id_rs1_i),
        .id_rs2_i           (id_rs2_i),
        .id_uses_rs1_i      (id_uses_rs1_i),
        .id_uses_rs2_i      (id_uses_rs2_i),
        .de_rd_i            (de_rd_i),
        .de_mem_read_i      (de_mem_read_i),
        .de_isbranchtaken_i (de_isbranchtaken_i),
        .de_jump_i          (de_jump_i),
        .dmem_req_i         (dmem_req_i),
        .dmem_ready_i       (dmem_ready_i),
        .pc_stall_o         (pc_stall_o),
        .fd_stall_o         (fd_stall_o),
        .fd_flush_o         (fd_flush_o),
        .de_flush_o         (de_flush_o),
        .em_stall_o         (em_stall_o),
        .state_o            (state_o),
        .mem_timeout_o      (mem_timeout_o),
        .stall_count_o      (stall_count_o),
        .flush_count_o      (flush_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;
    exp_t sb_q[$];

    // Reference model: "where the pipeline is" plus running totals.
    int    m_mode;      // 0 running, 1 squashing wrong-path fetch, 2 waiting on memory
    int    m_waited;
    int    m_to;
    int    m_sc;
    int    m_fc;
    exp_t  m_cur;
    stim_t m_in;

    task automatic model_reset();
        m_mode   = 0;
        m_waited = 0;
        m_to     = 0;
        m_sc     = 0;
        m_fc     = 0;
    endtask

    function automatic exp_t model_eval(input logic rst, input stim_t s);
        exp_t e;
        bit lu, rd_hit, busy;
        e = '{default: 0};
        rd_hit = (s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd);
        lu     = s.mr && (s.rd != 0) && rd_hit;
        busy   = s.req && !s.rdy;
        if (rst) begin
            if (m_mode == 0) begin
                if (busy)                    begin e.pc = 1; e.fds = 1; e.em = 1; end
                else if (s.br || s.jp)       begin e.fdf = 1; e.def = 1; end
                else if (lu)                 begin e.pc = 1; e.fds = 1; e.def = 1; end
            end else if (m_mode == 1) begin
                e.fdf = 1;
            end else if (!s.rdy) begin
                e.pc = 1; e.fds = 1; e.em = 1;
            end
        end
        e.st = m_mode;
        e.to = m_to;
        e.sc = m_sc;
        e.fc = m_fc;
        return e;
    endfunction

    task automatic model_advance();
        bit busy;
        busy = m_in.req && !m_in.rdy;
        if (m_cur.pc != 0)                     m_sc = (m_sc < c_CNT_MAX) ? m_sc + 1 : m_sc;
        if (m_cur.fdf != 0 || m_cur.def != 0) m_fc = (m_fc < c_CNT_MAX) ? m_fc + 1 : m_fc;
        case (m_mode)
            0: begin
                if (busy) begin m_mode = 2; m_waited = 0; end
                else if (m_in.br || m_in.jp) m_mode = 1;
            end
            1: m_mode = busy ? 2 : 0;
            default: begin
                if (m_in.rdy) begin
                    m_mode = 0;
                    m_waited = 0;
                end else begin
                    m_waited++;
                    if (m_waited == c_TIMEOUT) begin
                        m_to = 1;
                        m_mode = 0;
                        m_waited = 0;
                    end
                end
            end
        endcase
    endtask

    // One cycle: settle the model on the edge, then drive and queue expectations.
    task automatic step(input logic rst, input stim_t s, input bit chk);
        @(posedge clk);
        if (reset_i) model_advance();
        #1;
        reset_i            = rst;
        id_rs1_i           = s.rs1;
        id_rs2_i           = s.rs2;
        id_uses_rs1_i      = s.u1;
        id_uses_rs2_i      = s.u2;
        de_rd_i            = s.rd;
        de_mem_read_i      = s.mr;
        de_isbranchtaken_i = s.br;
        de_jump_i          = s.jp;
        dmem_req_i         = s.req;
        dmem_ready_i       = s.rdy;
        if (!rst) model_reset();
        m_in      = s;
        m_cur     = model_eval(rst, s);
        m_cur.chk = chk;
        m_cur.cyc = ncyc;
        sb_q.push_back(m_cur);
        ncyc++;
    endtask

    task automatic cmp(input string nm, input int cyc, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                cmp("pc_stall",    mon_e.cyc, int'(pc_stall_o),    mon_e.pc);
                cmp("fd_stall",    mon_e.cyc, int'(fd_stall_o),    mon_e.fds);
                cmp("fd_flush",    mon_e.cyc, int'(fd_flush_o),    mon_e.fdf);
                cmp("de_flush",    mon_e.cyc, int'(de_flush_o),    mon_e.def);
                cmp("em_stall",    mon_e.cyc, int'(em_stall_o),    mon_e.em);
                cmp("state",       mon_e.cyc, int'(state_o),       mon_e.st);
                cmp("mem_timeout", mon_e.cyc, int'(mem_timeout_o), mon_e.to);
                cmp("stall_count", mon_e.cyc, int'(stall_count_o), mon_e.sc);
                cmp("flush_count", mon_e.cyc, int'(flush_count_o), mon_e.fc);
            end
        end
    end

    stim_t idle, lu5, busy_s, s;

    initial begin
        idle = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd3, default: 1'b0};
        lu5  = idle;
        lu5.mr = 1'b1; lu5.rd = 5'd5; lu5.rs1 = 5'd5; lu5.u1 = 1'b1;
        busy_s = idle;
        busy_s.req = 1'b1;

        reset_i = 1'b0;
        id_rs1_i = '0; id_rs2_i = '0; de_rd_i = '0;
        id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; de_mem_read_i = 1'b0;
        de_isbranchtaken_i = 1'b0; de_jump_i = 1'b0;
        dmem_req_i = 1'b0; dmem_ready_i = 1'b0;
        model_reset();
        m_in  = idle;
        m_cur = model_eval(1'b0, idle);

        // Reset held with hazards present, then release.
        step(1'b0, lu5, 1'b1);
        step(1'b0, busy_s, 1'b1);
        step(1'b1, idle, 1'b1);

        // Single load-use bubble.
        step(1'b1, lu5, 1'b1);
        repeat (2) step(1'b1, idle, 1'b1);

        // Taken branch, then a jump.
        s = idle; s.br = 1'b1;
        step(1'b1, s, 1'b1);
        repeat (3) step(1'b1, idle, 1'b1);
        s = idle; s.jp = 1'b1;
        step(1'b1, s, 1'b1);
        repeat (2) step(1'b1, idle, 1'b1);

        // Memory wait resolved after three stalled cycles.
        repeat (3) step(1'b1, busy_s, 1'b1);
        s = busy_s; s.rdy = 1'b1;
        step(1'b1, s, 1'b1);
        repeat (2) step(1'b1, idle, 1'b1);

        // Memory never answers: timeout after four waiting cycles.
        repeat (5) step(1'b1, busy_s, 1'b1);
        repeat (3) step(1'b1, idle, 1'b1);

        // rd = x0 never stalls; redirect outranks load-use; busy outranks redirect.
        s = lu5; s.rd = 5'd0; s.rs1 = 5'd0;
        step(1'b1, s, 1'b1);
        s = lu5; s.br = 1'b1;
        step(1'b1, s, 1'b1);
        step(1'b1, lu5, 1'b1);
        s = lu5; s.u1 = 1'b0; s.u2 = 1'b1; s.rs2 = 5'd5;
        step(1'b1, s, 1'b1);
        s = busy_s; s.jp = 1'b1;
        step(1'b1, s, 1'b1);
        s = idle; s.rdy = 1'b1;
        step(1'b1, s, 1'b1);
        step(1'b1, idle, 1'b1);

        // Randomised traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.mr  = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 5) == 0);
            s.jp  = ($urandom_range(0, 7) == 0);
            s.req = ($urandom_range(0, 4) == 0);
            s.rdy = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 199) != 0), s, 1'b1);
        end

        // Reset asserted mid-MEM_WAIT and mid-redirect.
        step(1'b1, idle, 1'b1);
        repeat (2) step(1'b1, busy_s, 1'b1);
        step(1'b0, busy_s, 1'b1);
        step(1'b1, idle, 1'b1);
        s = idle; s.br = 1'b1;
        step(1'b1, s, 1'b1);
        step(1'b0, lu5, 1'b1);
        step(1'b1, idle, 1'b1);

        // Stall counter saturation.
        for (int i = 0; i < 65540; i++)
            step(1'b1, lu5, (i % 4096 == 0) || (i > 65530));
        repeat (2) step(1'b1, idle, 1'b1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
